avsd_pll_lock_det: RTL



---
 rtl/avsd_pll_pkg.sv | 21 ++
 rtl/avsd_edge_sync.sv | 29 ++
 rtl/avsd_pll_lock_det.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/avsd_pll_pkg.sv
// Shared types and default constants for the AVSD PLL lock detector.
// Optional feature macro: AVSD_PLL_PERIOD_AVG_EN (see avsd_pll_lock_det.sv).
package avsd_pll_pkg;

    // Lock state machine encoding; the codes are visible on the STATE port.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_TRACK  = 2'd2,
        ST_LOCKED = 2'd3
    } state_e;

    localparam int DEF_CNT_W      = 8;
    localparam int DEF_RATIO      = 8;
    localparam int DEF_TOL        = 1;
    localparam int DEF_LOCK_CNT   = 4;
    localparam int DEF_UNLOCK_CNT = 2;
    localparam int DEF_TIMEOUT    = 32;
    localparam int DEF_AVG_SH     = 2;

endpackage

// File: rtl/avsd_edge_sync.sv
// Two-flop synchronizer for the asynchronous reference clock, followed by a
// delay flop so a single-cycle pulse marks each synchronized rising edge.
module avsd_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic dly_q;

    // Synchronizer chain plus one delay stage for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~dly_q;

endmodule

// File: rtl/avsd_pll_lock_det.sv
// Frequency-ratio monitor and lock detector for the AVSD PLL clock domain.
// Counts CLK cycles between synchronized REF rising edges, reports the period
// and its signed error against RATIO, and runs a hysteretic lock FSM with a
// missing-reference timeout.
// Optional feature: define AVSD_PLL_PERIOD_AVG_EN to report PERIOD as an
// exponential average (shift AVG_SH); FREQ_ERR and lock decisions always use
// the raw measurement.
module avsd_pll_lock_det
    import avsd_pll_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int RATIO      = DEF_RATIO,
    parameter int TOL        = DEF_TOL,
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int UNLOCK_CNT = DEF_UNLOCK_CNT,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int AVG_SH     = DEF_AVG_SH
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN,
    input  logic                    REF,
    output logic [CNT_W-1:0]        PERIOD,
    output logic                    PERIOD_VLD,
    output logic signed [CNT_W:0]   FREQ_ERR,
    output logic                    LOCK,
    output logic                    NO_REF,
    output logic [1:0]              STATE
);

    localparam int GC_W = $clog2(LOCK_CNT + 1);
    localparam int BC_W = $clog2(UNLOCK_CNT + 1);
    localparam logic signed [CNT_W:0] RATIO_S = (CNT_W + 1)'(RATIO);
    localparam logic [CNT_W:0]        TOL_U   = (CNT_W + 1)'(TOL);
    localparam logic [CNT_W-1:0]      TMO_V   = CNT_W'(TIMEOUT);

    // Reject parameter sets where the counter could not hold the timeout or
    // the ratio would be unmeasurable.
    if (RATIO < 2 || TIMEOUT <= RATIO || TIMEOUT >= (1 << CNT_W) ||
        LOCK_CNT < 1 || UNLOCK_CNT < 1 || TOL < 0 || AVG_SH < 0) begin : g_param_chk
        $error("avsd_pll_lock_det: illegal parameter combination");
    end

    // Magnitude of a signed error, used for the tolerance window test.
    function automatic logic [CNT_W:0] mag(input logic signed [CNT_W:0] v);
        logic [CNT_W:0] r;
        if (v < 0) r = $unsigned(-v);
        else       r = $unsigned(v);
        return r;
    endfunction

    logic                   rise;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [GC_W-1:0]        good_q, good_d;
    logic [BC_W-1:0]        bad_q, bad_d;
    logic                   no_ref_q, no_ref_d;
    logic                   vld_q;
    logic [CNT_W-1:0]       per_q;
    logic [CNT_W-1:0]       per_new;
    logic signed [CNT_W:0]  err_q;
    logic signed [CNT_W:0]  meas_err;
    logic                   meas;
    logic                   tmo;
    logic                   good_win;

    avsd_edge_sync u_sync (
        .clk_i   (CLK),
        .rst_i   (RST),
        .async_i (REF),
        .rise_o  (rise)
    );

    // A measurement is the counter value at a rise while tracking or locked;
    // a rise always beats a coincident timeout.
    assign meas     = EN && rise && (state_q == ST_TRACK || state_q == ST_LOCKED);
    assign tmo      = EN && !rise && (state_q != ST_IDLE) && (cnt_q == TMO_V);
    assign meas_err = $signed({1'b0, cnt_q}) - RATIO_S;
    assign good_win = (mag(meas_err) <= TOL_U);

    // Window counter: restart at 1 on a rise, otherwise count up and hold at
    // the timeout value; idle or disabled keeps it cleared.
    always_comb begin
        cnt_d = cnt_q;
        if (!EN || state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (rise) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != TMO_V) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State register together with the hysteresis counters and NO_REF flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            no_ref_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            no_ref_q <= no_ref_d;
        end
    end

    // Next-state logic: disable beats timeout, timeout beats normal tracking.
    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        bad_d    = bad_q;
        no_ref_d = no_ref_q;
        if (!EN) begin
            state_d  = ST_IDLE;
            good_d   = '0;
            bad_d    = '0;
            no_ref_d = 1'b0;
        end else if (tmo) begin
            state_d  = ST_ACQ;
            good_d   = '0;
            bad_d    = '0;
            no_ref_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQ;
                end
                ST_ACQ: begin
                    if (rise) begin
                        state_d  = ST_TRACK;
                        good_d   = '0;
                        bad_d    = '0;
                        no_ref_d = 1'b0;
                    end
                end
                ST_TRACK: begin
                    if (rise) begin
                        bad_d = '0;
                        if (!good_win) begin
                            good_d = '0;
                        end else if (good_q == GC_W'(LOCK_CNT - 1)) begin
                            state_d = ST_LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + GC_W'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    if (rise) begin
                        good_d = '0;
                        if (good_win) begin
                            bad_d = '0;
                        end else if (bad_q == BC_W'(UNLOCK_CNT - 1)) begin
                            state_d = ST_TRACK;
                            bad_d   = '0;
                        end else begin
                            bad_d = bad_q + BC_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from the state register.
    always_comb begin
        LOCK   = (state_q == ST_LOCKED);
        STATE  = state_q;
        NO_REF = no_ref_q;
    end

`ifdef AVSD_PLL_PERIOD_AVG_EN
    localparam int ACC_W = CNT_W + AVG_SH;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             first_q;

    // One exponential-average step: acc += ((p << AVG_SH) - acc) >>> AVG_SH.
    function automatic logic [ACC_W-1:0] avg_step(input logic [ACC_W-1:0] acc,
                                                  input logic [CNT_W-1:0] p);
        logic signed [ACC_W:0] diff;
        diff = $signed({1'b0, ACC_W'(p) << AVG_SH}) - $signed({1'b0, acc});
        return acc + ACC_W'(diff >>> AVG_SH);
    endfunction

    // Accumulator next value: seeded by the first measurement after ACQ.
    always_comb begin
        acc_d = acc_q;
        if (meas) begin
            if (first_q) acc_d = ACC_W'(cnt_q) << AVG_SH;
            else         acc_d = avg_step(acc_q, cnt_q);
        end
    end

    // Seed flag re-arms whenever the monitor re-acquires or is disabled.
    always_ff @(posedge CLK) begin
        if (RST) begin
            first_q <= 1'b1;
        end else if (!EN || state_q == ST_ACQ) begin
            first_q <= 1'b1;
        end else if (meas) begin
            first_q <= 1'b0;
        end
    end

    // Accumulator storage; only read after the seed load.
    always_ff @(posedge CLK) begin
        acc_q <= acc_d;
    end

    assign per_new = acc_d[ACC_W-1:AVG_SH];
`else
    assign per_new = cnt_q;
`endif

    // Measurement outputs: one-cycle valid, PERIOD holds across disable.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_q <= 1'b0;
            per_q <= '0;
            err_q <= '0;
        end else if (!EN) begin
            vld_q <= 1'b0;
            err_q <= '0;
        end else begin
            vld_q <= meas;
            if (meas) begin
                per_q <= per_new;
                err_q <= meas_err;
            end
        end
    end

    assign PERIOD     = per_q;
    assign PERIOD_VLD = vld_q;
    assign FREQ_ERR   = err_q;

endmodule
